// File: rtl/ksz_bus_pkg.sv
// Shared types and constants for the KSZ8851 register-engine bus arbiter.
// Holds the engine state codes, the arbiter FSM encoding, the default
// timeout and the latched engine-command payload.
package ksz_bus_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 4096;
  localparam int unsigned TIMER_W         = 16;

  // Register-access engine state codes (as seen on its state output)
  localparam logic [3:0] ENG_ADDR0  = 4'b0000;
  localparam logic [3:0] ENG_ADDR1  = 4'b0001;
  localparam logic [3:0] ENG_ADDR2  = 4'b0010;
  localparam logic [3:0] ENG_ADDR3  = 4'b0011;
  localparam logic [3:0] ENG_READ1  = 4'b0100;
  localparam logic [3:0] ENG_READ2  = 4'b0101;
  localparam logic [3:0] ENG_WRITE0 = 4'b0110;
  localparam logic [3:0] ENG_WRITE1 = 4'b0111;
  localparam logic [3:0] ENG_WRITE2 = 4'b1000;
  localparam logic [3:0] ENG_WAIT   = 4'b1001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    BUSY  = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
  } arb_state_e;

  // Command fields latched from the owning requester onto the engine
  typedef struct packed {
    logic        wr;
    logic        length;
    logic        dummy;
    logic [7:0]  offset;
    logic [15:0] wdata;
  } eng_cmd_t;

endpackage

// File: rtl/ksz_bus_arbiter_rr_picker.sv
// Combinational round-robin selector.
// Ports: req (request vector), ptr (last winner); gnt_c (one-hot winner),
// idx_c (winner index), valid_c (any request present).
module rr_picker
  import ksz_bus_pkg::*;
#(
  parameter  int unsigned NREQ  = 3,
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             valid_c
);

  // First asserted request searching upward from ptr+1, wrapping modulo NREQ
  always_comb begin
    int unsigned j;
    gnt_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    j       = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      j = (32'(ptr) + i) % NREQ;
      if (req[j] && !valid_c) begin
        gnt_c[j] = 1'b1;
        idx_c    = IDX_W'(j);
        valid_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ksz_bus_arbiter.sv
// Round-robin arbiter sharing one KSZ8851 register-access engine between
// several sequencers, with lock-based grant retention and a command timeout.
// Ports: clk40m/reset; per-requester req, lock and command fields; gnt, ack
// and err per requester; rdata (last read result); engine command outputs
// NewCommand/WR/length/Dummy_Write/offset/writeData; engine readData/state.
module ksz_bus_arbiter
  import ksz_bus_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk40m,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [NREQ-1:0]     req_wr,
  input  logic [NREQ-1:0]     req_length,
  input  logic [NREQ-1:0]     req_dummy,
  input  logic [8*NREQ-1:0]   req_offset,
  input  logic [16*NREQ-1:0]  req_wdata,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     ack,
  output logic [NREQ-1:0]     err,
  output logic [15:0]         rdata,
  output logic                NewCommand,
  output logic                WR,
  output logic                length,
  output logic                Dummy_Write,
  output logic [7:0]          offset,
  output logic [15:0]         writeData,
  input  logic [15:0]         readData,
  input  logic [3:0]          state
);

  localparam int unsigned        IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);

  arb_state_e         arb_q, arb_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, owner_q, owner_d, sel_idx, pick_idx;
  logic [NREQ-1:0]    gnt_q, gnt_d, ack_q, ack_d, err_q, err_d, pick_gnt;
  logic               pick_valid;
  logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
  logic [15:0]        rdata_q, rdata_d;
  logic               newcmd_q, newcmd_d;
  eng_cmd_t           cmd_q, cmd_d, sel_cmd;
  logic               eng_accepted, tmo_hit;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_c   (pick_gnt),
    .idx_c   (pick_idx),
    .valid_c (pick_valid)
  );

  // Field mux: the arbitration winner in IDLE, the locked owner in HOLD
  always_comb begin
    sel_idx        = (arb_q == HOLD) ? owner_q : pick_idx;
    sel_cmd.wr     = req_wr[sel_idx];
    sel_cmd.length = req_length[sel_idx];
    sel_cmd.dummy  = req_dummy[sel_idx];
    sel_cmd.offset = req_offset[8*sel_idx +: 8];
    sel_cmd.wdata  = req_wdata[16*sel_idx +: 16];
  end

  assign eng_accepted = (state == ENG_READ1) || (state == ENG_WRITE1);
  assign tmo_hit      = (timer_q == TMO_LAST);
  assign timer_inc    = tmo_hit ? timer_q : timer_q + TIMER_W'(1);

  // Next-state and output logic
  always_comb begin
    arb_d    = arb_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    newcmd_d = newcmd_q;
    cmd_d    = cmd_q;

    case (arb_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d    = pick_gnt;
          owner_d  = pick_idx;
          ptr_d    = pick_idx;
          cmd_d    = sel_cmd;
          newcmd_d = 1'b1;
          timer_d  = '0;
          arb_d    = ISSUE;
        end
      end

      ISSUE: begin
        if (eng_accepted) begin
          newcmd_d = 1'b0;
          timer_d  = '0;
          arb_d    = BUSY;
        end else if (tmo_hit) begin
          err_d    = gnt_q;
          gnt_d    = '0;
          newcmd_d = 1'b0;
          arb_d    = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      BUSY: begin
        // The engine cannot be aborted, so a withdrawn req still completes
        if (state == ENG_WAIT) begin
          if (!cmd_q.wr) rdata_d = readData;
          ack_d = gnt_q;
          arb_d = DONE;
        end else if (tmo_hit) begin
          err_d = gnt_q;
          gnt_d = '0;
          arb_d = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      DONE: begin
        if (lock[owner_q]) begin
          arb_d = HOLD;
        end else begin
          gnt_d = '0;
          arb_d = IDLE;
        end
      end

      HOLD: begin
        // Lock release wins over a simultaneous request from the owner
        if (!lock[owner_q]) begin
          gnt_d = '0;
          arb_d = IDLE;
        end else if (req[owner_q]) begin
          cmd_d    = sel_cmd;
          newcmd_d = 1'b1;
          timer_d  = '0;
          arb_d    = ISSUE;
        end
      end

      default: begin
        gnt_d    = '0;
        newcmd_d = 1'b0;
        arb_d    = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk40m or posedge reset) begin
    if (reset) begin
      arb_q    <= IDLE;
      ptr_q    <= IDX_W'(NREQ - 1);
      owner_q  <= '0;
      timer_q  <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      newcmd_q <= 1'b0;
      cmd_q    <= '0;
    end else begin
      arb_q    <= arb_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      newcmd_q <= newcmd_d;
      cmd_q    <= cmd_d;
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign NewCommand  = newcmd_q;
  assign WR          = cmd_q.wr;
  assign length      = cmd_q.length;
  assign Dummy_Write = cmd_q.dummy;
  assign offset      = cmd_q.offset;
  assign writeData   = cmd_q.wdata;

endmodule
